// File: rtl/uart_tx_fifo_if.sv
// Byte handshake from the motor command generator into the UART transmit FIFO.
// The sender drives data/valid; the FIFO answers with ready.
interface uart_tx_fifo_if;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;

  modport master (output uart_tx_data, output uart_tx_valid, input uart_tx_ready);
  modport slave  (input uart_tx_data, input uart_tx_valid, output uart_tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a FIFO on a valid/ready handshake and
// leave as 8N1 frames (optional even parity) on a registered serial line.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               txIf,
  output logic                        uart_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q, count_d;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          uartOut_q;
  logic          full, notEmpty, push, pop, bitEnd;

  assign full     = (count_q == DEPTH_C);
  assign notEmpty = (count_q != '0);
  assign bitEnd   = (baud_q == BAUD_LAST);

  assign txIf.uart_tx_ready = !reset && !full;
  assign push = txIf.uart_tx_valid && txIf.uart_tx_ready;
  // Pop either from IDLE or on the final stop cycle so frames run back to back.
  assign pop  = notEmpty && ((state_q == IDLE) || ((state_q == STOP) && bitEnd));

  assign uart_out   = uartOut_q;
  assign busy       = (state_q != IDLE) || notEmpty;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= txIf.uart_tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      uartOut_q <= 1'b1;
    end else if (pop) begin
      state_q   <= START;
      baud_q    <= '0;
      shift_q   <= mem_q[rdPtr_q];
      parity_q  <= ^mem_q[rdPtr_q];
      uartOut_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q    <= '0;
          uartOut_q <= 1'b1;
        end
        START: begin
          if (!bitEnd) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q    <= '0;
            bitIdx_q  <= '0;
            state_q   <= DATA;
            uartOut_q <= shift_q[0];
          end
        end
        DATA: begin
          if (!bitEnd) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bitIdx_q == 3'd7) begin
              if (PARITY_EN) begin
                state_q   <= PARITY;
                uartOut_q <= parity_q;
              end else begin
                state_q   <= STOP;
                uartOut_q <= 1'b1;
              end
            end else begin
              bitIdx_q  <= bitIdx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              uartOut_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (!bitEnd) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q    <= '0;
            state_q   <= STOP;
            uartOut_q <= 1'b1;
          end
        end
        default: begin
          // Stop bit; a non-empty FIFO on the last cycle is handled by pop above.
          if (!bitEnd) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q    <= '0;
            state_q   <= IDLE;
            uartOut_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a plain-8N1 and an even-parity instance fed random
// byte streams, checked against a frame-level queue model and a line decoder.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  bit   trackMax = 1'b0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LEN = (k == 1) ? 11 : 10;

    uart_tx_fifo_if bus ();
    logic           uartOut;
    logic           busy;
    logic [CW-1:0]  fifoCount;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(k == 1)) dut (
      .clk       (clk),
      .reset     (reset),
      .txIf      (bus),
      .uart_out  (uartOut),
      .busy      (busy),
      .fifo_count(fifoCount)
    );

    logic [7:0]  srcQ[$];
    logic [7:0]  accLog[$];
    bit          randValid = 1'b0;
    bit          accNow;
    logic [7:0]  mQ[$];
    logic [10:0] mFrame = '1;
    bit          mActive = 1'b0;
    bit          mInit = 1'b0;
    int          mT = 0;
    int          rxPhase = -1;
    int          rxIdx = 0;
    int          maxCnt = 0;
    logic [7:0]  rxByte = '0;

    // Sender: presents the head of srcQ, logs each byte as it is accepted.
    initial begin
      bus.uart_tx_valid = 1'b0;
      bus.uart_tx_data  = '0;
      forever begin
        @(negedge clk);
        accNow = bus.uart_tx_valid && bus.uart_tx_ready;
        @(posedge clk);
        #2;
        if (accNow && srcQ.size() != 0) accLog.push_back(srcQ.pop_front());
        if (srcQ.size() != 0 && (!randValid || $urandom_range(0, 1) == 1)) begin
          bus.uart_tx_valid = 1'b1;
          bus.uart_tx_data  = srcQ[0];
        end else begin
          bus.uart_tx_valid = 1'b0;
          bus.uart_tx_data  = 8'($urandom);
        end
      end
    end

    // Model: a byte queue plus the frame currently on the line as a bit array.
    always @(posedge clk) begin
      int n;
      logic [7:0] b;
      if (reset) begin
        mQ.delete();
        mActive = 1'b0;
        mT      = 0;
        mInit   = 1'b1;
      end else if (mInit) begin
        n = mQ.size();
        if (mActive) begin
          mT++;
          if (mT == LEN * CPB) mActive = 1'b0;
        end
        if (!mActive && n != 0) begin
          b         = mQ.pop_front();
          mFrame    = '1;
          mFrame[0] = 1'b0;
          mFrame[8:1] = b;
          if (k == 1) mFrame[9] = ^b;
          mActive = 1'b1;
          mT      = 0;
        end
        if (bus.uart_tx_valid && n != DEPTH) mQ.push_back(bus.uart_tx_data);
      end
    end

    // Compare: every cycle against the model, plus a mid-bit line decoder.
    always @(negedge clk) begin
      int bi;
      if (mInit) begin
        checkOutput($sformatf("i%0d uart_out", k), uartOut, mActive ? mFrame[mT / CPB] : 1'b1);
        checkOutput($sformatf("i%0d busy", k), busy, mActive || mQ.size() != 0);
        checkOutput($sformatf("i%0d fifo_count", k), fifoCount, mQ.size());
        checkOutput($sformatf("i%0d ready", k), bus.uart_tx_ready, !reset && mQ.size() != DEPTH);
        if (!trackMax) maxCnt = 0;
        else if (fifoCount > maxCnt) maxCnt = fifoCount;

        if (reset) begin
          rxPhase = -1;
          rxIdx   = accLog.size();
        end else if (rxPhase < 0) begin
          if (uartOut == 1'b0) begin
            rxPhase = 0;
            rxByte  = '0;
          end
        end else begin
          rxPhase++;
          if (rxPhase % CPB == CPB / 2) begin
            bi = rxPhase / CPB;
            if (bi == 0) begin
              checkOutput($sformatf("i%0d rx start", k), uartOut, 1'b0);
            end else if (bi <= 8) begin
              rxByte[bi-1] = uartOut;
            end else if (bi == LEN - 1) begin
              checkOutput($sformatf("i%0d rx stop", k), uartOut, 1'b1);
              if (rxIdx < accLog.size())
                checkOutput($sformatf("i%0d rx byte %0d", k, rxIdx), rxByte, accLog[rxIdx]);
              else
                checkOutput($sformatf("i%0d rx unexpected frame", k), rxIdx, accLog.size());
              rxIdx++;
              rxPhase = -1;
            end else begin
              checkOutput($sformatf("i%0d rx parity", k), uartOut, ^rxByte);
            end
          end
        end
      end
    end
  end

  function automatic logic outOf(input int k);
    return (k == 0) ? g[0].uartOut : g[1].uartOut;
  endfunction

  function automatic logic busyOf(input int k);
    return (k == 0) ? g[0].busy : g[1].busy;
  endfunction

  function automatic logic acceptOf(input int k);
    return (k == 0) ? (g[0].bus.uart_tx_valid && g[0].bus.uart_tx_ready)
                    : (g[1].bus.uart_tx_valid && g[1].bus.uart_tx_ready);
  endfunction

  task automatic applyStimulus(input int k, input logic [7:0] b);
    if (k == 0) g[0].srcQ.push_back(b);
    else        g[1].srcQ.push_back(b);
  endtask

  // Waits for the next accept, then checks the serial pattern bit by bit.
  task automatic frameCheck(input int k, input logic [10:0] pat, input int len, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = acceptOf(k);
    end
    checkOutput({name, " accepted"}, got, 1'b1);
    if (!got) return;
    for (int j = 1; j <= CPB * len + 2; j++) begin
      @(negedge clk);
      if (j == 1) begin
        checkOutput({name, " line before start"}, outOf(k), 1'b1);
      end else if (j == CPB * len + 2) begin
        checkOutput({name, " line idle after"}, outOf(k), 1'b1);
        checkOutput({name, " busy cleared"}, busyOf(k), 1'b0);
      end else begin
        if ((j - 2) % CPB == 0)
          checkOutput($sformatf("%s bit%0d", name, (j - 2) / CPB), outOf(k), pat[(j - 2) / CPB]);
        if (j == CPB * len + 1)
          checkOutput({name, " busy in stop"}, busyOf(k), 1'b1);
      end
    end
  endtask

  task automatic waitIdle(input int k, input int limit);
    bit done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      @(negedge clk);
      done = (k == 0) ? (g[0].srcQ.size() == 0 && !g[0].busy)
                      : (g[1].srcQ.size() == 0 && !g[1].busy);
    end
    checkOutput($sformatf("i%0d drained", k), done, 1'b1);
    checkOutput($sformatf("i%0d decoded count", k),
                (k == 0) ? g[0].rxIdx : g[1].rxIdx,
                (k == 0) ? g[0].accLog.size() : g[1].accLog.size());
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  acc;
    bit  ok;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset uart_out", g[0].uartOut, 1'b1);
    checkOutput("reset busy", g[0].busy, 1'b0);
    checkOutput("reset fifo_count", g[0].fifoCount, 0);
    checkOutput("ready low in reset", g[0].bus.uart_tx_ready, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Quiet line after reset.
    repeat (1000) @(negedge clk);
    checkOutput("quiet uart_out", g[0].uartOut, 1'b1);
    checkOutput("quiet busy", g[0].busy, 1'b0);
    checkOutput("quiet ready", g[0].bus.uart_tx_ready, 1'b1);

    applyStimulus(0, 8'h7B);
    frameCheck(0, 11'b01011110110, 10, "byte 0x7B");

    applyStimulus(1, 8'h31);
    frameCheck(1, 11'b11001100010, 11, "parity 0x31");

    for (int i = 0; i < 26; i++) applyStimulus(0, 8'($urandom));
    acc = 0;
    ok  = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (acceptOf(0)) acc++;
      else if (acc > 0 && !g[0].bus.uart_tx_ready) ok = 1'b1;
    end
    checkOutput("burst accepts before full", acc, 17);
    checkOutput("burst fifo_count when full", g[0].fifoCount, 16);
    waitIdle(0, 1500);

    applyStimulus(0, 8'hA5);
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'h0F);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = (g[0].srcQ.size() == 0);
    end
    checkOutput("pre-reset bytes accepted", ok, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset ready", g[0].bus.uart_tx_ready, 1'b0);
    @(negedge clk);
    checkOutput("mid-frame reset uart_out", g[0].uartOut, 1'b1);
    checkOutput("mid-frame reset busy", g[0].busy, 1'b0);
    checkOutput("mid-frame reset fifo_count", g[0].fifoCount, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset release", g[0].bus.uart_tx_ready, 1'b1);
    applyStimulus(0, 8'h55);
    frameCheck(0, 11'b01010101010, 10, "post-reset 0x55");

    trackMax = 1'b1;
    g[0].randValid = 1'b1;
    g[1].randValid = 1'b1;
    for (int i = 0; i < 60; i++) applyStimulus(0, 8'($urandom));
    for (int i = 0; i < 60; i++) applyStimulus(1, 8'($urandom));
    waitIdle(0, 4000);
    waitIdle(1, 1500);
    checkOutput("peak fifo_count under random valid", g[0].maxCnt, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
